// File: rtl/iob_pcie_chnl_host_if.sv
// RIFFA channel signal bundle between the host/core end and the user logic.
// master = host/core end (drives CHNL_RX_*, consumes CHNL_TX_*); slave = user logic.
interface iob_pcie_chnl_host_if #(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64
);
  logic                        CHNL_RX;
  logic                        CHNL_RX_ACK;
  logic                        CHNL_RX_LAST;
  logic [DATA_W-1:0]           CHNL_RX_LEN;
  logic [DATA_W-2:0]           CHNL_RX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
  logic                        CHNL_RX_DATA_VALID;
  logic                        CHNL_RX_DATA_REN;

  logic                        CHNL_TX;
  logic                        CHNL_TX_ACK;
  logic                        CHNL_TX_LAST;
  logic [DATA_W-1:0]           CHNL_TX_LEN;
  logic [DATA_W-2:0]           CHNL_TX_OFF;
  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
  logic                        CHNL_TX_DATA_VALID;
  logic                        CHNL_TX_DATA_REN;

  modport master (
    output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    input  CHNL_RX_ACK, CHNL_RX_DATA_REN,
    input  CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    output CHNL_TX_ACK, CHNL_TX_DATA_REN
  );

  modport slave (
    input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
    output CHNL_RX_ACK, CHNL_RX_DATA_REN,
    output CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA, CHNL_TX_DATA_VALID,
    input  CHNL_TX_ACK, CHNL_TX_DATA_REN
  );
endinterface

// File: rtl/iob_pcie_chnl_host.sv
// Host/core end of a RIFFA channel: a send FSM feeding CHNL_RX_* to user logic and an
// independent receive FSM draining CHNL_TX_* from user logic into a beat sink.
module iob_pcie_chnl_host #(
  parameter int DATA_W           = 32,
  parameter int C_PCI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_W-1:0]           start_len,
  input  logic [DATA_W-2:0]           start_off,
  input  logic                        start_last,
  input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
  input  logic                        src_valid,
  output logic                        src_ready,
  output logic [C_PCI_DATA_WIDTH-1:0] snk_data,
  output logic                        snk_valid,
  input  logic                        snk_ready,
  output logic                        snk_last,
  output logic                        rx_busy,
  output logic                        tx_busy,
  output logic                        rx_done,
  output logic                        tx_done,
  output logic [DATA_W-1:0]           tx_len,
  output logic [DATA_W-2:0]           tx_off,
  output logic                        tx_last,
  iob_pcie_chnl_host_if.master        chnl
);

  localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   TWO_W = {{(DATA_W-1){1'b0}}, 2'b10};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} send_st_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA, R_WAIT} recv_st_t;

  send_st_t s_st, s_nxt;
  recv_st_t r_st, r_nxt;

  logic [DATA_W-1:0] s_cnt;
  logic [DATA_W-1:0] rx_len_q;
  logic [DATA_W-2:0] rx_off_q;
  logic              rx_last_q;
  logic              rx_done_q;
  logic              s_accept, s_beat, s_final;

  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W:0]   r_cnt_step;
  logic              tx_done_q;
  logic              r_take, r_beat, r_final, r_zero;

  // Beats needed for a word count: ceil(words/2), computed without overflowing DATA_W.
  function automatic logic [DATA_W-1:0] beat_count(input logic [DATA_W-1:0] words);
    beat_count = {1'b0, words[DATA_W-1:1]} + {{(DATA_W-1){1'b0}}, words[0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_st <= S_IDLE;
      r_st <= R_IDLE;
    end else begin
      s_st <= s_nxt;
      r_st <= r_nxt;
    end
  end

  always_comb begin
    s_nxt                   = s_st;
    s_accept                = 1'b0;
    s_beat                  = 1'b0;
    s_final                 = 1'b0;
    chnl.CHNL_RX            = 1'b0;
    chnl.CHNL_RX_DATA_VALID = 1'b0;
    chnl.CHNL_RX_DATA       = '0;
    src_ready               = 1'b0;
    rx_busy                 = 1'b0;
    case (s_st)
      S_IDLE: begin
        if (start && (start_len != '0)) begin
          s_accept = 1'b1;
          s_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        chnl.CHNL_RX = 1'b1;
        rx_busy      = 1'b1;
        if (chnl.CHNL_RX_ACK) s_nxt = S_DATA;
      end
      S_DATA: begin
        chnl.CHNL_RX            = 1'b1;
        rx_busy                 = 1'b1;
        chnl.CHNL_RX_DATA       = src_data;
        chnl.CHNL_RX_DATA_VALID = src_valid;
        src_ready               = chnl.CHNL_RX_DATA_REN;
        s_beat                  = src_valid && chnl.CHNL_RX_DATA_REN;
        s_final                 = s_beat && (s_cnt == ONE_W);
        if (s_final) s_nxt = S_IDLE;
      end
      default: s_nxt = S_IDLE;
    endcase
  end

  // Counter runs one beat ahead of the word count so an odd length over-counts by a word.
  assign r_cnt_step = {1'b0, r_cnt} + TWO_W;

  always_comb begin
    r_nxt                 = r_st;
    r_take                = 1'b0;
    r_beat                = 1'b0;
    r_final               = 1'b0;
    r_zero                = 1'b0;
    chnl.CHNL_TX_ACK      = 1'b0;
    chnl.CHNL_TX_DATA_REN = 1'b0;
    snk_data              = '0;
    snk_valid             = 1'b0;
    snk_last              = 1'b0;
    tx_busy               = 1'b0;
    case (r_st)
      R_IDLE: begin
        if (chnl.CHNL_TX) begin
          r_take = 1'b1;
          r_nxt  = R_ACK;
        end
      end
      R_ACK: begin
        tx_busy          = 1'b1;
        chnl.CHNL_TX_ACK = 1'b1;
        if (tx_len != '0) begin
          r_nxt = R_DATA;
        end else begin
          r_nxt  = R_WAIT;
          r_zero = 1'b1;
        end
      end
      R_DATA: begin
        tx_busy               = 1'b1;
        chnl.CHNL_TX_DATA_REN = snk_ready;
        snk_data              = chnl.CHNL_TX_DATA;
        snk_valid             = chnl.CHNL_TX_DATA_VALID;
        snk_last              = (r_cnt_step >= {1'b0, tx_len});
        r_beat                = chnl.CHNL_TX_DATA_VALID && snk_ready;
        if (r_beat && snk_last) begin
          r_final = 1'b1;
          r_nxt   = R_WAIT;
        end
      end
      R_WAIT: begin
        tx_busy = 1'b1;
        if (!chnl.CHNL_TX) r_nxt = R_IDLE;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt     <= '0;
      rx_len_q  <= '0;
      rx_off_q  <= '0;
      rx_last_q <= 1'b0;
      rx_done_q <= 1'b0;
      r_cnt     <= '0;
      tx_len    <= '0;
      tx_off    <= '0;
      tx_last   <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      rx_done_q <= s_final;
      tx_done_q <= r_final || r_zero;
      if (s_accept) begin
        rx_len_q  <= start_len;
        rx_off_q  <= start_off;
        rx_last_q <= start_last;
        s_cnt     <= beat_count(start_len);
      end else if (s_beat) begin
        s_cnt <= s_cnt - ONE_W;
      end
      if (r_take) begin
        tx_len  <= chnl.CHNL_TX_LEN;
        tx_off  <= chnl.CHNL_TX_OFF;
        tx_last <= chnl.CHNL_TX_LAST;
        r_cnt   <= '0;
      end else if (r_beat) begin
        r_cnt <= r_cnt_step[DATA_W-1:0];
      end
    end
  end

  assign chnl.CHNL_RX_LEN  = rx_len_q;
  assign chnl.CHNL_RX_OFF  = rx_off_q;
  assign chnl.CHNL_RX_LAST = rx_last_q;
  assign rx_done           = rx_done_q;
  assign tx_done           = tx_done_q;

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Bench for iob_pcie_chnl_host: acts as source, sink and RIFFA user logic, and checks
// beat counts, data pass-through, header latching and done/busy timing against a model.
module tb_iob_pcie_chnl_host;
  localparam int DW = 32;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] start_len;
  logic [DW-2:0] start_off;
  logic          start_last;
  logic [PW-1:0] src_data;
  logic          src_valid, src_ready;
  logic [PW-1:0] snk_data;
  logic          snk_valid, snk_ready, snk_last;
  logic          rx_busy, tx_busy, rx_done, tx_done;
  logic [DW-1:0] tx_len;
  logic [DW-2:0] tx_off;
  logic          tx_last;

  int n_chk  = 0;
  int n_pass = 0;

  iob_pcie_chnl_host_if #(.DATA_W(DW), .C_PCI_DATA_WIDTH(PW)) chnl ();

  iob_pcie_chnl_host #(.DATA_W(DW), .C_PCI_DATA_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .start(start), .start_len(start_len), .start_off(start_off), .start_last(start_last),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_last(snk_last),
    .rx_busy(rx_busy), .tx_busy(tx_busy), .rx_done(rx_done), .tx_done(tx_done),
    .tx_len(tx_len), .tx_off(tx_off), .tx_last(tx_last),
    .chnl(chnl)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int beats_for(input logic [DW-1:0] words);
    return int'((longint'(words) + 1) / 2);
  endfunction

  // Send: bench plays src producer and RIFFA user receiver. Starts and ends at posedge+1.
  task automatic send_xfer(input logic [DW-1:0] len, input logic [DW-2:0] off, input logic lst,
                           input int ack_dly, input int ren_mode, input bit rnd_valid,
                           input int abort_at, input string tag, output int cycles);
    int  exp_beats, beats, t;
    bit  acked, ren_ph, drv_v, drv_r;
    logic [PW-1:0] drv_d;
    exp_beats = beats_for(len);
    beats = 0; t = 0; acked = 1'b0; ren_ph = 1'b1;
    start = 1'b1; start_len = len; start_off = off; start_last = lst;
    tick();
    while (beats < exp_beats && t < 300) begin
      if (t == abort_at) begin
        cycles = t;
        return;
      end
      start     = 1'($urandom_range(0, 1));
      start_len = DW'($urandom_range(0, 20));
      start_off = '1;
      start_last = ~lst;
      chnl.CHNL_RX_ACK = !acked && (t >= ack_dly);
      drv_v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_d = {$urandom, $urandom};
      if (!acked)             drv_r = 1'($urandom_range(0, 1));
      else if (ren_mode == 0) drv_r = 1'b1;
      else if (ren_mode == 1) drv_r = ren_ph;
      else                    drv_r = 1'($urandom_range(0, 1));
      src_valid = drv_v; src_data = drv_d; chnl.CHNL_RX_DATA_REN = drv_r;
      #2;
      n_chk++;
      if (chnl.CHNL_RX !== 1'b1 || rx_busy !== 1'b1 || rx_done !== 1'b0)
        $display("FAIL %s busy t=%0d rx=%b busy=%b done=%b want 1/1/0", tag, t,
                 chnl.CHNL_RX, rx_busy, rx_done);
      else n_pass++;
      if (!acked) begin
        n_chk++;
        if (chnl.CHNL_RX_DATA_VALID !== 1'b0 || src_ready !== 1'b0)
          $display("FAIL %s req_idle_data t=%0d valid=%b ready=%b want 0/0", tag, t,
                   chnl.CHNL_RX_DATA_VALID, src_ready);
        else n_pass++;
        n_chk++;
        if (chnl.CHNL_RX_LEN !== len || chnl.CHNL_RX_OFF !== off || chnl.CHNL_RX_LAST !== lst)
          $display("FAIL %s req_hdr len=%0d off=%0h last=%b want %0d/%0h/%b", tag,
                   chnl.CHNL_RX_LEN, chnl.CHNL_RX_OFF, chnl.CHNL_RX_LAST, len, off, lst);
        else n_pass++;
      end else begin
        n_chk++;
        if (chnl.CHNL_RX_DATA_VALID !== drv_v || src_ready !== drv_r)
          $display("FAIL %s data_hs t=%0d valid=%b ready=%b want %b/%b", tag, t,
                   chnl.CHNL_RX_DATA_VALID, src_ready, drv_v, drv_r);
        else n_pass++;
        if (drv_v && drv_r) begin
          n_chk++;
          if (chnl.CHNL_RX_DATA !== drv_d)
            $display("FAIL %s beat%0d data=%h want %h", tag, beats, chnl.CHNL_RX_DATA, drv_d);
          else n_pass++;
          beats++;
        end
        ren_ph = ~ren_ph;
      end
      if (chnl.CHNL_RX_ACK) acked = 1'b1;
      tick();
      t++;
    end
    cycles = t;
    start = 1'b0; chnl.CHNL_RX_ACK = 1'b0; chnl.CHNL_RX_DATA_REN = 1'b1; src_valid = 1'b1;
    n_chk++;
    if (beats !== exp_beats) $display("FAIL %s beat_count got %0d want %0d", tag, beats, exp_beats);
    else n_pass++;
    #2;
    n_chk++;
    if (chnl.CHNL_RX !== 1'b0 || rx_done !== 1'b1 || rx_busy !== 1'b0 ||
        chnl.CHNL_RX_DATA_VALID !== 1'b0 || src_ready !== 1'b0)
      $display("FAIL %s end rx=%b done=%b busy=%b valid=%b ready=%b want 0/1/0/0/0", tag,
               chnl.CHNL_RX, rx_done, rx_busy, chnl.CHNL_RX_DATA_VALID, src_ready);
    else n_pass++;
    tick();
    src_valid = 1'b0; chnl.CHNL_RX_DATA_REN = 1'b0;
    #2;
    n_chk++;
    if (rx_done !== 1'b0 || chnl.CHNL_RX_LEN !== len || chnl.CHNL_RX_LAST !== lst)
      $display("FAIL %s after done=%b len=%0d last=%b want 0/%0d/%b", tag, rx_done,
               chnl.CHNL_RX_LEN, chnl.CHNL_RX_LAST, len, lst);
    else n_pass++;
    tick();
  endtask

  // Receive: bench plays RIFFA user sender and snk consumer. Starts and ends at posedge+1.
  task automatic recv_xfer(input logic [DW-1:0] len, input logic [DW-2:0] off, input logic lst,
                           input int rdy_mode, input bit rnd_valid, input int abort_at,
                           input string tag, output int cycles);
    int  exp_beats, beats, t;
    bit  drv_v, drv_r;
    logic [PW-1:0] drv_d;
    exp_beats = beats_for(len);
    beats = 0; t = 0;
    chnl.CHNL_TX = 1'b1; chnl.CHNL_TX_LEN = len; chnl.CHNL_TX_OFF = off; chnl.CHNL_TX_LAST = lst;
    chnl.CHNL_TX_DATA_VALID = 1'b1; snk_ready = 1'b1;
    #2;
    n_chk++;
    if (chnl.CHNL_TX_ACK !== 1'b0 || tx_busy !== 1'b0 || chnl.CHNL_TX_DATA_REN !== 1'b0)
      $display("FAIL %s idle ack=%b busy=%b ren=%b want 0/0/0", tag, chnl.CHNL_TX_ACK, tx_busy,
               chnl.CHNL_TX_DATA_REN);
    else n_pass++;
    tick();
    chnl.CHNL_TX_LEN = DW'($urandom_range(0, 50));
    #2;
    n_chk++;
    if (chnl.CHNL_TX_ACK !== 1'b1 || tx_busy !== 1'b1 || chnl.CHNL_TX_DATA_REN !== 1'b0 ||
        snk_valid !== 1'b0)
      $display("FAIL %s ack ack=%b busy=%b ren=%b sv=%b want 1/1/0/0", tag, chnl.CHNL_TX_ACK,
               tx_busy, chnl.CHNL_TX_DATA_REN, snk_valid);
    else n_pass++;
    n_chk++;
    if (tx_len !== len || tx_off !== off || tx_last !== lst)
      $display("FAIL %s hdr tx_len=%0d off=%0h last=%b want %0d/%0h/%b", tag, tx_len, tx_off,
               tx_last, len, off, lst);
    else n_pass++;
    tick();
    while (beats < exp_beats && t < 300) begin
      if (t == abort_at) begin
        cycles = t;
        return;
      end
      drv_v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_r = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      drv_d = {$urandom, $urandom};
      chnl.CHNL_TX_DATA_VALID = drv_v; chnl.CHNL_TX_DATA = drv_d; snk_ready = drv_r;
      #2;
      n_chk++;
      if (chnl.CHNL_TX_ACK !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0 ||
          chnl.CHNL_TX_DATA_REN !== drv_r || snk_valid !== drv_v)
        $display("FAIL %s data_hs t=%0d ack=%b busy=%b done=%b ren=%b sv=%b want 0/1/0/%b/%b",
                 tag, t, chnl.CHNL_TX_ACK, tx_busy, tx_done, chnl.CHNL_TX_DATA_REN, snk_valid,
                 drv_r, drv_v);
      else n_pass++;
      if (drv_v && drv_r) begin
        n_chk++;
        if (snk_data !== drv_d || snk_last !== (beats == exp_beats - 1))
          $display("FAIL %s beat%0d data=%h last=%b want %h/%b", tag, beats, snk_data, snk_last,
                   drv_d, (beats == exp_beats - 1));
        else n_pass++;
        beats++;
      end
      tick();
      t++;
    end
    cycles = t;
    n_chk++;
    if (beats !== exp_beats) $display("FAIL %s beat_count got %0d want %0d", tag, beats, exp_beats);
    else n_pass++;
    chnl.CHNL_TX_DATA_VALID = 1'b1; snk_ready = 1'b1;
    #2;
    n_chk++;
    if (tx_done !== 1'b1 || chnl.CHNL_TX_DATA_REN !== 1'b0 || snk_valid !== 1'b0 || tx_busy !== 1'b1)
      $display("FAIL %s wait1 done=%b ren=%b sv=%b busy=%b want 1/0/0/1", tag, tx_done,
               chnl.CHNL_TX_DATA_REN, snk_valid, tx_busy);
    else n_pass++;
    tick();
    #2;
    n_chk++;
    if (tx_done !== 1'b0 || tx_busy !== 1'b1 || chnl.CHNL_TX_ACK !== 1'b0)
      $display("FAIL %s wait2 done=%b busy=%b ack=%b want 0/1/0", tag, tx_done, tx_busy,
               chnl.CHNL_TX_ACK);
    else n_pass++;
    tick();
    chnl.CHNL_TX = 1'b0; chnl.CHNL_TX_DATA_VALID = 1'b0;
    tick();
    #2;
    n_chk++;
    if (tx_busy !== 1'b0 || tx_len !== len)
      $display("FAIL %s back_idle busy=%b tx_len=%0d want 0/%0d", tag, tx_busy, tx_len, len);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; start_len = '0; start_off = '0; start_last = 1'b0;
    src_data = '0; src_valid = 1'b0; snk_ready = 1'b0;
    chnl.CHNL_RX_ACK = 1'b0; chnl.CHNL_RX_DATA_REN = 1'b0;
    chnl.CHNL_TX = 1'b0; chnl.CHNL_TX_LEN = '0; chnl.CHNL_TX_OFF = '0; chnl.CHNL_TX_LAST = 1'b0;
    chnl.CHNL_TX_DATA = '0; chnl.CHNL_TX_DATA_VALID = 1'b0;
    tick(); tick();
    n_chk++;
    if ({chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID, chnl.CHNL_RX_LAST, src_ready, rx_busy, rx_done} !== 6'b0)
      $display("FAIL reset_rx_ctrl got %b want 000000", {chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID,
               chnl.CHNL_RX_LAST, src_ready, rx_busy, rx_done});
    else n_pass++;
    n_chk++;
    if ({chnl.CHNL_TX_ACK, chnl.CHNL_TX_DATA_REN, snk_valid, snk_last, tx_busy, tx_done, tx_last} !== 7'b0)
      $display("FAIL reset_tx_ctrl got %b want 0000000", {chnl.CHNL_TX_ACK, chnl.CHNL_TX_DATA_REN,
               snk_valid, snk_last, tx_busy, tx_done, tx_last});
    else n_pass++;
    n_chk++;
    if (chnl.CHNL_RX_LEN !== '0 || chnl.CHNL_RX_OFF !== '0 || tx_len !== '0 || tx_off !== '0 ||
        chnl.CHNL_RX_DATA !== '0 || snk_data !== '0)
      $display("FAIL reset_values rxlen=%0d rxoff=%0h txlen=%0d txoff=%0h want all 0",
               chnl.CHNL_RX_LEN, chnl.CHNL_RX_OFF, tx_len, tx_off);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_send_basic();
    int cyc;
    send_xfer(32'd4, 31'h0000_1234, 1'b1, 2, 0, 1'b0, -1, "send4", cyc);
    n_chk++;
    if (cyc !== 5) $display("FAIL send4 latency got %0d cycles want 5", cyc);
    else n_pass++;
  endtask

  task automatic test_send_odd_toggle();
    int cyc;
    send_xfer(32'd3, 31'h55, 1'b0, 1, 1, 1'b0, -1, "send3_tog", cyc);
    n_chk++;
    if (cyc !== 5) $display("FAIL send3_tog latency got %0d cycles want 5", cyc);
    else n_pass++;
  endtask

  task automatic test_ignore_zero_start();
    start = 1'b1; start_len = '0; start_off = 31'h7; start_last = 1'b1;
    tick();
    start = 1'b0;
    #2;
    n_chk++;
    if (chnl.CHNL_RX !== 1'b0 || rx_busy !== 1'b0 || chnl.CHNL_RX_LEN !== 32'd3)
      $display("FAIL zero_start rx=%b busy=%b len=%0d want 0/0/3", chnl.CHNL_RX, rx_busy,
               chnl.CHNL_RX_LEN);
    else n_pass++;
    tick();
  endtask

  task automatic test_recv_odd();
    int cyc;
    recv_xfer(32'd5, 31'h4321, 1'b1, 0, 1'b0, -1, "recv5", cyc);
    n_chk++;
    if (cyc !== 3) $display("FAIL recv5 data_cycles got %0d want 3", cyc);
    else n_pass++;
  endtask

  task automatic test_recv_zero();
    int cyc;
    recv_xfer(32'd0, 31'h9, 1'b0, 0, 1'b0, -1, "recv0", cyc);
    n_chk++;
    if (cyc !== 0) $display("FAIL recv0 data_cycles got %0d want 0", cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c1, c2;
    fork
      send_xfer(32'd8, 31'h11, 1'b1, 0, 0, 1'b0, 3, "mid_send", c1);
      recv_xfer(32'd8, 31'h22, 1'b1, 0, 1'b0, 2, "mid_recv", c2);
    join
    start = 1'b0; src_valid = 1'b0; chnl.CHNL_RX_DATA_REN = 1'b0;
    chnl.CHNL_TX = 1'b0; chnl.CHNL_TX_DATA_VALID = 1'b0; snk_ready = 1'b0;
    #1;
    n_chk++;
    if (rx_busy !== 1'b1 || tx_busy !== 1'b1)
      $display("FAIL mid_busy rx_busy=%b tx_busy=%b want 1/1", rx_busy, tx_busy);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID, rx_busy, rx_done, chnl.CHNL_TX_ACK,
         snk_last, tx_busy, tx_done} !== 8'b0 || chnl.CHNL_RX_LEN !== '0 || tx_len !== '0)
      $display("FAIL mid_reset ctrl=%b rxlen=%0d txlen=%0d want 0/0/0",
               {chnl.CHNL_RX, chnl.CHNL_RX_DATA_VALID, rx_busy, rx_done, chnl.CHNL_TX_ACK,
                snk_last, tx_busy, tx_done}, chnl.CHNL_RX_LEN, tx_len);
    else n_pass++;
    tick();
    rst = 1'b0;
    #2;
    n_chk++;
    if (rx_done !== 1'b0 || tx_done !== 1'b0)
      $display("FAIL mid_no_done rx_done=%b tx_done=%b want 0/0", rx_done, tx_done);
    else n_pass++;
    tick();
    send_xfer(32'd2, 31'h33, 1'b0, 0, 0, 1'b0, -1, "post_rst_send", c1);
    recv_xfer(32'd2, 31'h44, 1'b0, 0, 1'b0, -1, "post_rst_recv", c2);
  endtask

  task automatic test_concurrent();
    int c1, c2;
    fork
      send_xfer(32'd2, 31'h101, 1'b1, 1, 0, 1'b0, -1, "conc_send", c1);
      recv_xfer(32'd2, 31'h202, 1'b1, 0, 1'b0, -1, "conc_recv", c2);
    join
  endtask

  task automatic test_random();
    int c1, c2;
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] sl, rl;
      sl = DW'($urandom_range(1, 11));
      rl = DW'($urandom_range(0, 11));
      fork
        send_xfer(sl, 31'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 2, 1'b1, -1,
                  "rnd_send", c1);
        recv_xfer(rl, 31'($urandom), 1'($urandom_range(0, 1)), 1, 1'b1, -1, "rnd_recv", c2);
      join
    end
  endtask

  initial begin
    test_reset();
    test_send_basic();
    test_send_odd_toggle();
    test_ignore_zero_start();
    test_recv_odd();
    test_recv_zero();
    test_reset_mid();
    test_concurrent();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/iob_pcie_chnl_host.md
IOB_PCIE_CHNL_HOST -- requirements
Module: iob_pcie_chnl_host

Interface
REQ-001 Parameter DATA_W, default 32: RIFFA word width; width of lengths and word counters.
REQ-002 Parameter C_PCI_DATA_WIDTH, default 64: channel data beat width (2 words per beat).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  pulse: begin a host-to-user transfer of start_len words.
REQ-007 start_len, start_off, start_last  in  DATA_W / DATA_W-1 / 1  transfer length in words, offset, last flag; sampled on accepted start.
REQ-008 src_data  in  64, src_valid  in  1, src_ready  out  1: outgoing beat source.
REQ-009 snk_data  out  64, snk_valid  out  1, snk_ready  in  1, snk_last  out  1: incoming beat sink; snk_last marks the final beat of a transfer.
REQ-010 rx_busy, tx_busy  out  1 each; rx_done, tx_done  out  1 each, single-cycle pulses.
REQ-011 tx_len  out  DATA_W, tx_off  out  DATA_W-1, tx_last  out  1: header of the current or most recent user-to-host transfer.
REQ-012 CHNL_RX  out  1; CHNL_RX_ACK  in  1; CHNL_RX_LAST  out  1; CHNL_RX_LEN  out  DATA_W; CHNL_RX_OFF  out  DATA_W-1; CHNL_RX_DATA  out  64; CHNL_RX_DATA_VALID  out  1; CHNL_RX_DATA_REN  in  1.
REQ-013 CHNL_TX  in  1; CHNL_TX_ACK  out  1; CHNL_TX_LAST  in  1; CHNL_TX_LEN  in  DATA_W; CHNL_TX_OFF  in  DATA_W-1; CHNL_TX_DATA  in  64; CHNL_TX_DATA_VALID  in  1; CHNL_TX_DATA_REN  out  1.

Function
REQ-014 Block is the host/core end of the RIFFA channel: drives CHNL_RX_* to user logic, consumes CHNL_TX_* from user logic; two independent FSMs, may run concurrently.
REQ-015 Beat rule: a beat transfers on a cycle with DATA_VALID=1 and DATA_REN=1 of the same direction; lower 32 bits carry the earlier word.
REQ-016 Beat count = ceil(len/2); for odd len the upper word of the final beat is don't-care (passed through unchanged).
REQ-017 Send FSM states: S_IDLE, S_REQ, S_DATA.
REQ-018 S_IDLE: start=1 with start_len!=0 -> latch len/off/last, load remaining-beat counter, go S_REQ next cycle; start with start_len=0 or while not S_IDLE is ignored.
REQ-019 S_REQ: CHNL_RX=1, CHNL_RX_LEN/OFF/LAST = latched values, CHNL_RX_DATA_VALID=0; CHNL_RX_ACK=1 -> S_DATA.
REQ-020 S_DATA: CHNL_RX=1; CHNL_RX_DATA=src_data; CHNL_RX_DATA_VALID=src_valid; src_ready=CHNL_RX_DATA_REN; each transferred beat decrements counter.
REQ-021 Transfer of the beat with counter=1 -> S_IDLE next cycle, CHNL_RX=0 that cycle, rx_done=1 for exactly that cycle.
REQ-022 src_ready=0 and CHNL_RX_DATA_VALID=0 outside S_DATA; rx_busy=1 in S_REQ and S_DATA.
REQ-023 Receive FSM states: R_IDLE, R_ACK, R_DATA, R_WAIT.
REQ-024 R_IDLE: CHNL_TX=1 -> latch CHNL_TX_LEN/OFF/LAST into tx_len/tx_off/tx_last, clear word counter, go R_ACK.
REQ-025 R_ACK: CHNL_TX_ACK=1 for exactly one cycle; next state R_DATA if tx_len!=0, else R_WAIT with tx_done=1 that cycle.
REQ-026 R_DATA: CHNL_TX_DATA_REN=snk_ready; snk_data=CHNL_TX_DATA; snk_valid=CHNL_TX_DATA_VALID; each beat adds 2 to the word counter.
REQ-027 Beat with counter+2 >= tx_len: snk_last=1 on that beat; go R_WAIT, tx_done=1 next cycle.
REQ-028 R_WAIT: CHNL_TX_DATA_REN=0; return to R_IDLE when CHNL_TX=0; a new CHNL_TX rising while in R_WAIT is not possible without deassertion and is not detected.
REQ-029 CHNL_TX_DATA_REN=0 and snk_valid=0 outside R_DATA; tx_busy=1 in R_ACK, R_DATA, R_WAIT.
REQ-030 Word counter width DATA_W, no wrap: compare is >=, so over-count by one word on odd len terminates correctly.
REQ-031 CHNL_RX_LEN/OFF/LAST hold latched values from S_REQ until next accepted start.

Reset
REQ-032 rst=1 forces both FSMs to IDLE immediately, including mid-transfer; on-going transfers are abandoned, no done pulse.
REQ-033 Reset values: all outputs 0; latched len/off/last, tx_len/tx_off/tx_last, counters 0.
REQ-034 First start is honoured on the first clock edge after rst deasserts.

Verification
REQ-035 start, start_len=4, src always valid, user ACK 2 cycles after CHNL_RX, REN=1 -> 2 beats after ACK, CHNL_RX=0 and rx_done=1 the cycle after 2nd beat.
REQ-036 start_len=3, REN toggling 1/0 -> exactly 2 beats transferred, CHNL_RX_DATA_VALID only in S_DATA, rx_done once.
REQ-037 CHNL_TX=1, CHNL_TX_LEN=5, snk_ready=1, VALID each cycle -> CHNL_TX_ACK one cycle, 3 beats, snk_last on 3rd, tx_done=1, tx_len=5.
REQ-038 CHNL_TX_LEN=0 -> one-cycle ACK, tx_done=1, no REN, returns R_IDLE after CHNL_TX=0.
REQ-039 rst pulsed mid S_DATA and mid R_DATA -> all outputs 0 same cycle, no done pulse, new start then completes normally.
REQ-040 Concurrent send len=2 and receive len=2 -> both complete independently, rx_done and tx_done each pulse once.
